// File: rtl/flash_loader.sv
// flash_loader
//   Bulk copy engine: on start, reads `length` bytes one at a time from the
//   SPI flash byte reader (24-bit byte address) and writes them to a byte-wide
//   memory port starting at dst_addr. Pulses done after the last write.
//
// Optional feature macro: FLASH_LOADER_CSUM_EN
//   defined   : csum is a running 16-bit sum of the bytes written by the
//               current (or most recent) copy.
//   undefined : csum is tied to 0.
//
// Ports
//   clk, reset       clock, synchronous active-high reset
//   start            command strobe, sampled only while idle
//   src_addr         first flash byte address (sampled with start)
//   dst_addr         first destination address (sampled with start)
//   length           byte count 0..2^ADDR_W (sampled with start)
//   busy, done       status; done is a one-cycle completion pulse
//   flash_valid/addr request to the flash reader
//   flash_ready/rdata one-cycle data-valid pulse and byte from the reader
//   mem_we/addr/wdata byte write port
//   csum             running checksum
module flash_loader #(
    parameter int ADDR_W = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [23:0]       src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              flash_valid,
    output logic [23:0]       flash_addr,
    input  logic              flash_ready,
    input  logic [7:0]        flash_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic [15:0]       csum
);

    typedef enum logic [1:0] {IDLE, REQ, WR, DONE} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W:0]   remain_reg, remain_next;
    logic [23:0]       src_reg, src_next;
    logic [ADDR_W-1:0] dst_reg, dst_next;

    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              flash_valid_reg, flash_valid_next;
    logic [23:0]       flash_addr_reg, flash_addr_next;
    logic              mem_we_reg, mem_we_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [7:0]        mem_wdata_reg, mem_wdata_next;

`ifdef FLASH_LOADER_CSUM_EN
    logic [15:0]       csum_reg, csum_next;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            remain_reg      <= '0;
            src_reg         <= '0;
            dst_reg         <= '0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            flash_valid_reg <= 1'b0;
            flash_addr_reg  <= '0;
            mem_we_reg      <= 1'b0;
            mem_addr_reg    <= '0;
            mem_wdata_reg   <= '0;
`ifdef FLASH_LOADER_CSUM_EN
            csum_reg        <= '0;
`endif
        end else begin
            state_reg       <= state_next;
            remain_reg      <= remain_next;
            src_reg         <= src_next;
            dst_reg         <= dst_next;
            busy_reg        <= busy_next;
            done_reg        <= done_next;
            flash_valid_reg <= flash_valid_next;
            flash_addr_reg  <= flash_addr_next;
            mem_we_reg      <= mem_we_next;
            mem_addr_reg    <= mem_addr_next;
            mem_wdata_reg   <= mem_wdata_next;
`ifdef FLASH_LOADER_CSUM_EN
            csum_reg        <= csum_next;
`endif
        end
    end

    always_comb begin
        state_next       = state_reg;
        remain_next      = remain_reg;
        src_next         = src_reg;
        dst_next         = dst_reg;
        busy_next        = busy_reg;
        done_next        = 1'b0;
        flash_valid_next = flash_valid_reg;
        flash_addr_next  = flash_addr_reg;
        mem_we_next      = 1'b0;
        mem_addr_next    = mem_addr_reg;
        mem_wdata_next   = mem_wdata_reg;
`ifdef FLASH_LOADER_CSUM_EN
        csum_next        = csum_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (start) begin
                    src_next    = src_addr;
                    dst_next    = dst_addr;
                    remain_next = length;
                    busy_next   = 1'b1;
`ifdef FLASH_LOADER_CSUM_EN
                    csum_next   = '0;
`endif
                    if (length == '0) begin
                        // Empty copy: report completion immediately.
                        state_next = DONE;
                        done_next  = 1'b1;
                    end else begin
                        state_next       = REQ;
                        flash_valid_next = 1'b1;
                        flash_addr_next  = src_addr;
                    end
                end
            end

            REQ: begin
                if (flash_ready) begin
                    state_next       = WR;
                    flash_valid_next = 1'b0;
                    mem_we_next      = 1'b1;
                    mem_wdata_next   = flash_rdata;
                    mem_addr_next    = dst_reg;
                    remain_next      = remain_reg - (ADDR_W+1)'(1);
`ifdef FLASH_LOADER_CSUM_EN
                    csum_next        = csum_reg + {8'd0, flash_rdata};
`endif
                end
            end

            WR: begin
                // This cycle keeps flash_valid low so the reader sees a clean
                // gap between requests.
                if (remain_reg == '0) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                end else begin
                    // Both increments wrap naturally at their register width.
                    src_next         = src_reg + 24'd1;
                    dst_next         = dst_reg + ADDR_W'(1);
                    flash_valid_next = 1'b1;
                    flash_addr_next  = src_reg + 24'd1;
                    state_next       = REQ;
                end
            end

            DONE: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end

            default: state_next = IDLE;
        endcase
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign flash_valid = flash_valid_reg;
    assign flash_addr  = flash_addr_reg;
    assign mem_we      = mem_we_reg;
    assign mem_addr    = mem_addr_reg;
    assign mem_wdata   = mem_wdata_reg;

`ifdef FLASH_LOADER_CSUM_EN
    assign csum = csum_reg;
`else
    assign csum = 16'd0;
`endif

endmodule
